// File: rtl/add_approx_pkg.sv
// Shared types and slice-boundary helpers for the pipelined approximate adder.
// Optional error monitor in the top is enabled by defining ADD_APPROX_ERR_MON_EN.
package add_approx_pkg;

   // Control part of one pipeline stage record; data vectors are sized per instance.
   typedef struct packed {
      logic valid;
      logic approx;
      logic carry;
   } stage_ctl_t;

   function automatic int seg_width(input int w, input int stages);
      return (w + stages - 1) / stages;
   endfunction

   function automatic int slice_lo(input int k, input int seg);
      return k * seg;
   endfunction

   // The last populated slice is clipped to the operand width; later slices are empty.
   function automatic int slice_hi(input int k, input int seg, input int w);
      int hi;
      hi = (k + 1) * seg - 1;
      if (hi > w - 1) hi = w - 1;
      return hi;
   endfunction

endpackage

// File: rtl/add_approx_stage.sv
// One pipeline slice: adds bits LO..HI of the carried operands and registers the
// partial sum, carry, mode and valid under the shared advance enable.
module add_approx_stage
   import add_approx_pkg::*;
#(
   parameter int W        = 8,
   parameter int LOA_BITS = 2,
   parameter int LO       = 0,
   parameter int HI       = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         advance,
   input  logic         in_valid,
   input  logic         in_approx,
   input  logic         in_carry,
   input  logic [W-1:0] in_sum,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         out_valid,
   output logic         out_approx,
   output logic         out_carry,
   output logic [W-1:0] out_sum,
   output logic [W-1:0] out_a,
   output logic [W-1:0] out_b
);

   stage_ctl_t   ctl_q;
   logic [W-1:0] sum_q, a_q, b_q;
   logic [W-1:0] sum_nxt;
   logic         carry_nxt;

   // NOTE: the ripple carry is a variable updated bit by bit, so blocking '=' is
   // required here; defaults come first so no bit path can infer a latch.
   always_comb begin
      sum_nxt   = in_sum;
      carry_nxt = in_carry;
      for (int i = 0; i < W; i++) begin
         if (i >= LO && i <= HI) begin
            if (in_approx && i < LOA_BITS) begin
               sum_nxt[i] = in_a[i] | in_b[i];
               // Only the top approximated bit feeds a carry into the exact part.
               carry_nxt  = (i == LOA_BITS - 1) ? (in_a[i] & in_b[i]) : 1'b0;
            end else begin
               sum_nxt[i] = in_a[i] ^ in_b[i] ^ carry_nxt;
               carry_nxt  = (in_a[i] & in_b[i]) | (carry_nxt & (in_a[i] ^ in_b[i]));
            end
         end
      end
   end

   // NOTE: data registers are reset along with valid so a flushed pipeline shows
   // zeros rather than stale operands on its outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctl_q <= '0;
         sum_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
      end else if (advance) begin
         ctl_q.valid  <= in_valid;
         ctl_q.approx <= in_approx;
         ctl_q.carry  <= carry_nxt;
         sum_q        <= sum_nxt;
         a_q          <= in_a;
         b_q          <= in_b;
      end
   end

   assign out_valid  = ctl_q.valid;
   assign out_approx = ctl_q.approx;
   assign out_carry  = ctl_q.carry;
   assign out_sum    = sum_q;
   assign out_a      = a_q;
   assign out_b      = b_q;

endmodule

// File: rtl/add_approx_pipe.sv
// Pipelined exact / lower-part-OR approximate adder with valid/ready handshake.
// Define ADD_APPROX_ERR_MON_EN to add err_clr/err_cnt/err_max and a shadow exact pipeline.
module add_approx_pipe
   import add_approx_pkg::*;
#(
   parameter int W        = 8,
   parameter int STAGES   = 2,
   parameter int LOA_BITS = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_approx,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W:0]   out_sum,
   output logic         out_approx
`ifdef ADD_APPROX_ERR_MON_EN
   ,
   input  logic         err_clr,
   output logic [31:0]  err_cnt,
   output logic [W:0]   err_max
`endif
);

   localparam int SEG = seg_width(W, STAGES);

   logic         advance;
   logic [STAGES:0] valid_ch, approx_ch, carry_ch;
   logic [W-1:0] sum_ch [STAGES+1];
   logic [W-1:0] a_ch   [STAGES+1];
   logic [W-1:0] b_ch   [STAGES+1];

   // The whole pipeline moves together; bubbles travel like data.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   assign valid_ch[0]  = in_valid;
   assign approx_ch[0] = in_approx;
   assign carry_ch[0]  = 1'b0;
   assign sum_ch[0]    = '0;
   assign a_ch[0]      = in_a;
   assign b_ch[0]      = in_b;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      add_approx_stage #(
         .W        (W),
         .LOA_BITS (LOA_BITS),
         .LO       (slice_lo(k, SEG)),
         .HI       (slice_hi(k, SEG, W))
      ) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .advance    (advance),
         .in_valid   (valid_ch[k]),
         .in_approx  (approx_ch[k]),
         .in_carry   (carry_ch[k]),
         .in_sum     (sum_ch[k]),
         .in_a       (a_ch[k]),
         .in_b       (b_ch[k]),
         .out_valid  (valid_ch[k+1]),
         .out_approx (approx_ch[k+1]),
         .out_carry  (carry_ch[k+1]),
         .out_sum    (sum_ch[k+1]),
         .out_a      (a_ch[k+1]),
         .out_b      (b_ch[k+1])
      );
   end

   assign out_valid  = valid_ch[STAGES];
   assign out_approx = approx_ch[STAGES];
   assign out_sum    = {carry_ch[STAGES], sum_ch[STAGES]};

   // Operands leaving the last stage have been fully consumed.
   logic unused_tail;
   assign unused_tail = &{1'b0, a_ch[STAGES], b_ch[STAGES]};

`ifdef ADD_APPROX_ERR_MON_EN
   logic [W:0] exact_q [STAGES];
   logic [W:0] exact_out;
   logic [W:0] err_abs;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) exact_q[k] <= '0;
      end else if (advance) begin
         exact_q[0] <= {1'b0, in_a} + {1'b0, in_b};
         for (int k = 1; k < STAGES; k++) exact_q[k] <= exact_q[k-1];
      end
   end

   assign exact_out = exact_q[STAGES-1];

   always_comb begin
      err_abs = '0;
      if (out_sum > exact_out) err_abs = out_sum - exact_out;
      else                     err_abs = exact_out - out_sum;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_cnt <= '0;
         err_max <= '0;
      end else if (err_clr) begin
         err_cnt <= '0;
         err_max <= '0;
      end else if (out_valid && out_ready && out_approx && err_abs != '0) begin
         if (err_cnt != '1) err_cnt <= err_cnt + 32'd1;
         if (err_abs > err_max) err_max <= err_abs;
      end
   end
`endif

endmodule

// File: tb/tb_add_approx_pipe.sv
// Scoreboard bench for add_approx_pipe: directed corner cases, random stream with
// random back-pressure, stall/hold, mid-flight reset, optional error monitor.
module tb_add_approx_pipe;

   localparam int W      = 8;
   localparam int STAGES = 2;
   localparam int L      = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_approx = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_ready, out_valid, out_approx;
   logic [W:0]   out_sum;
`ifdef ADD_APPROX_ERR_MON_EN
   logic         err_clr = 1'b0;
   logic [31:0]  err_cnt;
   logic [W:0]   err_max;
`endif

   add_approx_pipe #(.W(W), .STAGES(STAGES), .LOA_BITS(L)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_approx  (in_approx),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sum    (out_sum),
      .out_approx (out_approx)
`ifdef ADD_APPROX_ERR_MON_EN
      ,
      .err_clr    (err_clr),
      .err_cnt    (err_cnt),
      .err_max    (err_max)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       approx;
      logic [W:0] sum;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp_head;
   int   n_vec = 0;
   int   n_bad = 0;
   int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: low L bits are OR'd, carry into bit L is the AND of bit L-1, upper part adds.
   function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic m);
      int unsigned ia, ib, lo, hi, cy;
      ia = a;
      ib = b;
      if (!m || L == 0) return (W+1)'(ia + ib);
      lo = (ia | ib) & ((1 << L) - 1);
      cy = ((ia & ib) >> (L - 1)) & 1;
      hi = (ia >> L) + (ib >> L) + cy;
      return (W+1)'((hi << L) | lo);
   endfunction

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: pops on every output transfer and checks hold stability during stalls.
   logic         stall_pending = 1'b0;
   logic [W+1:0] held = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_pending = 1'b0;
      end else begin
         if (stall_pending) begin
            check("stall_valid_held", out_valid, 1);
            check("stall_data_stable", {out_approx, out_sum}, held);
         end
         if (out_valid && out_ready) begin
            check("output_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               exp_head = exp_q.pop_front();
               check("out_sum", out_sum, exp_head.sum);
               check("out_approx", out_approx, exp_head.approx);
            end
         end
         stall_pending = out_valid && !out_ready;
         held          = {out_approx, out_sum};
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       input logic [W:0] want);
      int n = 0;
      bit done = 0;
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_approx = m;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back('{m, want});
            done = 1;
         end
         @(posedge clk);
         #1;
         n++;
         if (!done && n > 100) begin
            check("in_ready_within_budget", in_ready, 1);
            done = 1;
         end
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      in_valid = 1'b0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({name, "_drained"}, exp_q.size(), 0);
   endtask

   // Called at #1 after the accepting edge with an otherwise empty pipeline.
   task automatic check_latency(input string name);
      int cyc = 1;
      in_valid = 1'b0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check(name, cyc, STAGES);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ra, rb;
      logic         rm;
      int           accepted;

      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_out_sum", out_sum, 0);
      check("reset_out_approx", out_approx, 0);
      check("reset_in_ready", in_ready, 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed corner cases.
      send(8'h03, 8'h01, 1'b0, 9'h004);
      check_latency("latency_exact");
      drain("dir0");
      send(8'h03, 8'h01, 1'b1, 9'h003);
      send(8'hFF, 8'hFF, 1'b1, 9'h1FF);
      send(8'hFF, 8'hFF, 1'b0, 9'h1FE);
      send(8'h02, 8'h02, 1'b1, 9'h006);
      send(8'h00, 8'h00, 1'b1, 9'h000);
      drain("dir1");

      // Random stream, alternating mode, random back-pressure.
      ready_mode = 2;
      for (int i = 0; i < 16; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rm = 1'(i % 2);
         send(ra, rb, rm, ref_sum(ra, rb, rm));
      end
      drain("random");
      ready_mode = 1;

      // Stall: out_ready low for 5 cycles with input always offered.
      ready_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      accepted = 0;
      for (int i = 0; i < 5; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rm = 1'($urandom_range(0, 1));
         in_valid  = 1'b1;
         in_a      = ra;
         in_b      = rb;
         in_approx = rm;
         @(negedge clk);
         if (out_valid) check("in_ready_low_when_full", in_ready, 0);
         if (in_ready) begin
            exp_q.push_back('{rm, ref_sum(ra, rb, rm)});
            accepted++;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("held_count", accepted, STAGES);
      ready_mode = 1;
      drain("stall");

      // Reset with two transactions in flight.
      ready_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      send(8'h11, 8'h22, 1'b0, 9'h033);
      send(8'h44, 8'h55, 1'b1, ref_sum(8'h44, 8'h55, 1'b1));
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midreset_out_valid", out_valid, 0);
      check("midreset_in_ready", in_ready, 1);
      exp_q.delete();
      rst_n = 1'b1;
      ready_mode = 1;
      send(8'h5A, 8'h33, 1'b0, ref_sum(8'h5A, 8'h33, 1'b0));
      check_latency("latency_after_reset");
      drain("post_reset");

`ifdef ADD_APPROX_ERR_MON_EN
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      send(8'h03, 8'h01, 1'b1, 9'h003);
      send(8'h0F, 8'h01, 1'b1, 9'h00F);
      drain("errmon");
      @(posedge clk);
      #1;
      check("err_cnt", err_cnt, 2);
      check("err_max", err_max, 1);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      check("err_cnt_clr", err_cnt, 0);
      check("err_max_clr", err_max, 0);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/add_approx_pipe.md
Name: add_approx_pipe

Overview:
- Parametrised, pipelined approximate adder. Successor to the fixed 8-bit combinational approximate adders in the adders library.
- Adds two W-bit operands over STAGES register stages with a valid/ready handshake.
- A per-transaction mode bit selects exact addition or approximate lower-part-OR addition.
- Used in datapath experiments that trade accuracy for area and delay at run time.

Parameters:
W, 8, operand width in bits; W >= 2.
STAGES, 2, number of pipeline register stages; 1 <= STAGES <= W. Each stage resolves ceil(W/STAGES) bits, and the last stage takes the remainder.
LOA_BITS, 2, number of low bits approximated in approx mode; 0 <= LOA_BITS < W.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept this cycle
in_a  in  W  operand A
in_b  in  W  operand B
in_approx  in  1  1 = approximate mode, 0 = exact
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_sum  out  W+1  sum including carry-out
out_approx  out  1  mode the result was computed with

Behaviour:
- Reset: rst_n low at a rising edge clears every stage valid bit and all data and carry registers. After reset, out_valid=0, out_sum=0, out_approx=0, and in_ready=1.
- Reset mid-operation discards all in-flight transactions. Nothing is replayed.
- Pipeline advance: advance = !out_valid | out_ready, and in_ready = advance (combinational).
- When advance=0 the whole pipeline holds. Bubbles (valid=0) travel down the pipeline like data.
- Transfer rules:
  - Input is taken when in_valid & in_ready.
  - Output is consumed when out_valid & out_ready.
  - Latency is exactly STAGES cycles from input transfer to out_valid when there is no back-pressure.
  - Throughput is 1 per cycle.
- Stage k adds its bit slice of A and B with the carry registered from stage k-1. The upper slices of A and B ride along in registers. The mode bit is carried with the data.
- Exact mode: out_sum = in_a + in_b, zero-extended to W+1 bits.
- Approx mode with LOA_BITS=L>0:
  - sum[L-1:0] = a[L-1:0] | b[L-1:0].
  - Carry into bit L = a[L-1] & b[L-1].
  - Bits L..W use a normal ripple add from that carry.
- LOA_BITS=0: approx mode is identical to exact mode.
- Mode can change every transaction. There is no flush or penalty.
- out_sum and out_approx stay stable while out_valid=1 and out_ready=0. The handshake requires this.
- Wrap-around: there is no overflow. The carry-out is always in out_sum[W].

Optional Feature:
ADD_APPROX_ERR_MON_EN.
- When defined, extra outputs are added:
  - err_cnt (32 bits): number of delivered approx-mode results whose value differs from the exact sum. It saturates at 2^32-1.
  - err_max (W+1 bits): largest absolute error seen.
  - A 1-bit input err_clr clears both, and err_clr takes priority over an update in the same cycle.
- The exact sum is computed in a shadow pipeline.
- Counters update only on output transfer. Both counters reset to 0.
- When not defined, these ports and all shadow logic are absent.

Decomposition:
- Package add_approx_pkg holds:
  - function slice_lo(k) and slice_hi(k), the stage bit boundaries;
  - localparam SEG = ceil(W/STAGES);
  - typedef of the stage record {valid, approx, carry, partial sum, remaining A/B}.
- One sub-module, add_approx_stage: one pipeline slice with its register and hold enable. It is instantiated STAGES times in a generate loop.

Test Plan:
- W=8, STAGES=2, L=2. After reset, out_valid=0, out_sum=0, in_ready=1. Send a=0x03, b=0x01, exact -> after 2 cycles out_sum=0x004.
- Same operands in approx mode -> out_sum=0x003. a=0xFF, b=0xFF, approx -> 0x1FF. Same operands exact -> 0x1FE.
- Back-to-back stream of 16 random pairs with alternating mode and out_ready toggling on a random pattern:
  - results arrive in order and match a reference model;
  - no loss or duplication;
  - out_sum is stable during stalls.
- Hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 once out_valid=1, and exactly STAGES transactions are held.
- Pull rst_n low with 2 transactions in flight -> out_valid=0 on the next cycle, and the next input completes after STAGES cycles.
- With ADD_APPROX_ERR_MON_EN: send approx pairs (0x03,0x01) then (0x0F,0x01) -> err_cnt=2, err_max=1. Assert err_clr -> both 0.
